// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with ihit/dhit handshakes and request timeout.
// Optional MCU_PERF_CNT_EN adds retired-instruction and stall counters.
module multicycle_control_unit #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              ir_en,
  output logic              pc_en,
  output logic [1:0]        PCSel,
  output logic              regWrite,
  output logic              memtoReg,
  output logic              wdataSrc,
  output logic              aluSrc,
  output logic [3:0]        ALUop,
  output logic [REG_AW-1:0] rsel1,
  output logic [REG_AW-1:0] rsel2,
  output logic [REG_AW-1:0] wsel,
  output logic [WORD_W-1:0] immediate,
  output logic              halt,
  output logic              mem_err,
  output logic [2:0]        state
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [31:0]       instr_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LastWait = CW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam logic [3:0] AluSll = 4'd0, AluSrl = 4'd1, AluAdd = 4'd2, AluSub = 4'd3;
  localparam logic [3:0] AluAnd = 4'd4, AluOr = 4'd5, AluXor = 4'd6, AluNor = 4'd7;
  localparam logic [3:0] AluSlt = 4'd8, AluSltu = 4'd9;

  localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04;
  localparam logic [5:0] OpBne = 6'h05, OpAddiu = 6'h09, OpSlti = 6'h0A, OpAndi = 6'h0C;
  localparam logic [5:0] OpOri = 6'h0D, OpXori = 6'h0E, OpLui = 6'h0F, OpLw = 6'h23;
  localparam logic [5:0] OpSw = 6'h2B, OpHalt = 6'h3F;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];

  logic aluOp, isLw, isSw, isBeq, isBne, isJ, isJal, isJr, isLui, isHalt, zeroExt;

  // Instruction decode; selects are always driven from the latched instruction.
  always_comb begin
    aluOp   = 1'b0;
    isJr    = 1'b0;
    zeroExt = 1'b0;
    aluSrc  = 1'b0;
    ALUop   = AluAdd;
    case (opcode)
      OpRtype: begin
        aluOp = 1'b1;
        case (funct)
          6'h00:        ALUop = AluSll;
          6'h02:        ALUop = AluSrl;
          6'h20, 6'h21: ALUop = AluAdd;
          6'h22, 6'h23: ALUop = AluSub;
          6'h24:        ALUop = AluAnd;
          6'h25:        ALUop = AluOr;
          6'h26:        ALUop = AluXor;
          6'h27:        ALUop = AluNor;
          6'h2A:        ALUop = AluSlt;
          6'h2B:        ALUop = AluSltu;
          6'h08: begin
            aluOp = 1'b0;
            isJr  = 1'b1;
          end
          default:      aluOp = 1'b0;
        endcase
      end
      OpAddiu: begin aluOp = 1'b1; aluSrc = 1'b1; ALUop = AluAdd; end
      OpSlti:  begin aluOp = 1'b1; aluSrc = 1'b1; ALUop = AluSlt; end
      OpAndi:  begin aluOp = 1'b1; aluSrc = 1'b1; ALUop = AluAnd; zeroExt = 1'b1; end
      OpOri:   begin aluOp = 1'b1; aluSrc = 1'b1; ALUop = AluOr;  zeroExt = 1'b1; end
      OpXori:  begin aluOp = 1'b1; aluSrc = 1'b1; ALUop = AluXor; zeroExt = 1'b1; end
      OpLui:   begin aluOp = 1'b1; aluSrc = 1'b1; ALUop = AluAdd; end
      OpLw, OpSw: begin aluSrc = 1'b1; ALUop = AluAdd; end
      OpBeq, OpBne: ALUop = AluSub;
      default: ;
    endcase
  end

  assign isLw   = (opcode == OpLw);
  assign isSw   = (opcode == OpSw);
  assign isBeq  = (opcode == OpBeq);
  assign isBne  = (opcode == OpBne);
  assign isJ    = (opcode == OpJ);
  assign isJal  = (opcode == OpJal);
  assign isLui  = (opcode == OpLui);
  assign isHalt = (opcode == OpHalt);

  assign memtoReg = isLw;
  assign wdataSrc = isJal;
  assign rsel1    = isLui ? '0 : REG_AW'(rs);
  assign rsel2    = REG_AW'(rt);
  assign wsel     = isJal ? REG_AW'(31) : ((opcode == OpRtype) ? REG_AW'(rd) : REG_AW'(rt));

  always_comb begin
    if (isLui)        immediate = {imm16, {(WORD_W-16){1'b0}}};
    else if (zeroExt) immediate = {{(WORD_W-16){1'b0}}, imm16};
    else              immediate = {{(WORD_W-16){imm16[15]}}, imm16};
  end

  logic [2:0]    nextState;
  logic [CW-1:0] waitCnt;
  logic          waiting;

  assign waiting = ((state == FETCH) && !ihit) || ((state == MEM) && !dhit);

  always_comb begin
    nextState = state;
    iREN      = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    PCSel     = 2'd0;
    regWrite  = 1'b0;
    case (state)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          ir_en     = 1'b1;
          nextState = DECODE;
        end else if (waitCnt == LastWait) begin
          nextState = ERR;
        end
      end
      DECODE: nextState = isHalt ? HALT : EXEC;
      EXEC: begin
        if (isBeq || isBne) begin
          pc_en     = 1'b1;
          PCSel     = (zero ^ isBne) ? 2'd1 : 2'd0;
          nextState = FETCH;
        end else if (isJ) begin
          pc_en     = 1'b1;
          PCSel     = 2'd2;
          nextState = FETCH;
        end else if (isJr) begin
          pc_en     = 1'b1;
          PCSel     = 2'd3;
          nextState = FETCH;
        end else if (isLw || isSw) begin
          nextState = MEM;
        end else begin
          nextState = WB;
        end
      end
      MEM: begin
        dREN = isLw;
        dWEN = isSw;
        if (dhit) begin
          if (isLw) begin
            nextState = WB;
          end else begin
            pc_en     = 1'b1;
            nextState = FETCH;
          end
        end else if (waitCnt == LastWait) begin
          nextState = ERR;
        end
      end
      WB: begin
        pc_en     = 1'b1;
        regWrite  = aluOp || isLw || isJal;
        PCSel     = isJal ? 2'd2 : 2'd0;
        nextState = FETCH;
      end
      HALT, ERR: nextState = state;
      default:   nextState = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= FETCH;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (nextState != state) waitCnt <= '0;
      else if (waiting)       waitCnt <= waitCnt + 1'b1;
    end
  end

  // HALT and ERR are absorbing, so the flags are sticky until reset.
  assign halt    = (state == HALT);
  assign mem_err = (state == ERR);

`ifdef MCU_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pc_en)   instr_cnt <= instr_cnt + 32'd1;
      if (waiting) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: instruction table plus hand-written corner cases.
module tb_multicycle_control_unit;

  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, MEM = 3'd3, HALT = 3'd5, ERR = 3'd6;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic [31:0] instr = '0;
  logic        ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
  logic        iREN, dREN, dWEN, ir_en, pc_en, regWrite, memtoReg, wdataSrc, aluSrc;
  logic        halt, mem_err;
  logic [1:0]  PCSel;
  logic [3:0]  ALUop;
  logic [4:0]  rsel1, rsel2, wsel;
  logic [31:0] immediate;
  logic [2:0]  state;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  multicycle_control_unit #(.WORD_W(32), .REG_AW(5), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .ir_en(ir_en), .pc_en(pc_en), .PCSel(PCSel),
    .regWrite(regWrite), .memtoReg(memtoReg), .wdataSrc(wdataSrc), .aluSrc(aluSrc),
    .ALUop(ALUop), .rsel1(rsel1), .rsel2(rsel2), .wsel(wsel), .immediate(immediate),
    .halt(halt), .mem_err(mem_err), .state(state)
`ifdef MCU_PERF_CNT_EN
    , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        z;
    int          lat;
    logic        rw, mtr, wds, asrc, rd, wr, chkSel, chkImm;
    logic [1:0]  pcs;
    logic [3:0]  aop;
    logic [4:0]  ws, rs1;
    logic [31:0] imm;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [31:0] ins, input logic z,
                              input int lat, input logic rw, input logic mtr, input logic wds,
                              input logic asrc, input logic rd, input logic wr,
                              input logic [1:0] pcs, input logic [3:0] aop, input logic [4:0] ws,
                              input logic [4:0] rs1, input logic [31:0] imm,
                              input logic chkSel, input logic chkImm);
    vec_t v;
    v.name = name; v.ins = ins; v.z = z; v.lat = lat; v.rw = rw; v.mtr = mtr; v.wds = wds;
    v.asrc = asrc; v.rd = rd; v.wr = wr; v.pcs = pcs; v.aop = aop; v.ws = ws; v.rs1 = rs1;
    v.imm = imm; v.chkSel = chkSel; v.chkImm = chkImm;
    return v;
  endfunction

  // Values captured on the cycle pc_en fires.
  int          latency, totalCycles, rdCycles, wrCycles, irEnExtra;
  logic        irEnFirst, capRw, capMtr, capWds, capAsrc;
  logic [1:0]  capPcs;
  logic [3:0]  capAop;
  logic [4:0]  capWs, capRs1;
  logic [31:0] capImm;

  // Starts at a negedge in FETCH, returns at the negedge after the pc_en cycle.
  task automatic runInstr(input logic [31:0] ins, input logic z, input int dWaits,
                          input bit noisy);
    int cyc, waits;
    bit done;
    cyc = 1; waits = 0; done = 0;
    latency = 0; totalCycles = 0; rdCycles = 0; wrCycles = 0; irEnExtra = 0;
    instr = ins; zero = z; ihit = 1'b1; dhit = noisy;
    #1 irEnFirst = ir_en;
    @(negedge CLK);
    while (!done && cyc < 20) begin
      cyc++;
      ihit = noisy;
      dhit = (state == MEM) ? (waits >= dWaits) : noisy;
      #1;
      if (ir_en) irEnExtra++;
      if (dREN) rdCycles++;
      if (dWEN) wrCycles++;
      if (pc_en) begin
        done = 1; latency = cyc - waits; totalCycles = cyc;
        capRw = regWrite; capMtr = memtoReg; capWds = wdataSrc; capAsrc = aluSrc;
        capPcs = PCSel; capAop = ALUop; capWs = wsel; capRs1 = rsel1; capImm = immediate;
      end else if (state == MEM && !dhit) begin
        waits++;
      end
      @(negedge CLK);
    end
    ihit = 1'b0; dhit = 1'b0;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  vec_t vecs[18];

  initial begin
    //            name        instr         z lat rw mtr wds asrc rd wr pcs aop ws  rs1 imm          sel imm
    vecs[0]  = mk("addu",     32'h00221821, 0, 4, 1, 0, 0, 0, 0, 0, 0, 2, 3,  1,  32'h0,        1, 0);
    vecs[1]  = mk("lw",       32'h8C220004, 0, 5, 1, 1, 0, 1, 1, 0, 0, 2, 2,  1,  32'h4,        1, 1);
    vecs[2]  = mk("sw",       32'hAC85FFF8, 0, 4, 0, 0, 0, 1, 0, 1, 0, 2, 5,  4,  32'hFFFFFFF8, 1, 1);
    vecs[3]  = mk("bne_z0",   32'h14220003, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 2,  1,  32'h3,        0, 1);
    vecs[4]  = mk("bne_z1",   32'h14220003, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2,  1,  32'h3,        0, 1);
    vecs[5]  = mk("beq_z1",   32'h10220003, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 2,  1,  32'h3,        0, 1);
    vecs[6]  = mk("beq_z0",   32'h10220003, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2,  1,  32'h3,        0, 1);
    vecs[7]  = mk("j",        32'h08000010, 0, 3, 0, 0, 0, 0, 0, 0, 2, 0, 0,  0,  32'h0,        0, 0);
    vecs[8]  = mk("jr",       32'h03E00008, 0, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0,  31, 32'h0,        0, 0);
    vecs[9]  = mk("jal",      32'h0C000010, 0, 4, 1, 0, 1, 0, 0, 0, 2, 0, 31, 0,  32'h0,        0, 0);
    vecs[10] = mk("lui",      32'h3C071234, 0, 4, 1, 0, 0, 1, 0, 0, 0, 2, 7,  0,  32'h12340000, 1, 1);
    vecs[11] = mk("ori",      32'h34248001, 0, 4, 1, 0, 0, 1, 0, 0, 0, 5, 4,  1,  32'h00008001, 1, 1);
    vecs[12] = mk("addiu",    32'h2424FFFF, 0, 4, 1, 0, 0, 1, 0, 0, 0, 2, 4,  1,  32'hFFFFFFFF, 1, 1);
    vecs[13] = mk("subu",     32'h00223023, 0, 4, 1, 0, 0, 0, 0, 0, 0, 3, 6,  1,  32'h0,        1, 0);
    vecs[14] = mk("sll",      32'h00031100, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 2,  0,  32'h0,        1, 0);
    vecs[15] = mk("slt",      32'h0022402A, 0, 4, 1, 0, 0, 0, 0, 0, 0, 8, 8,  1,  32'h0,        1, 0);
    vecs[16] = mk("bad_op",   32'hF8000000, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  32'h0,        0, 0);
    vecs[17] = mk("bad_fn",   32'h0022183F, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 3,  1,  32'h0,        0, 0);

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_state", 32'(state), 32'(FETCH));
    chk("rst_iREN", 32'(iREN), 1);
    chk("rst_strobes", {dREN, dWEN, ir_en, pc_en, regWrite}, 0);
    chk("rst_flags", {halt, mem_err}, 0);
`ifdef MCU_PERF_CNT_EN
    chk("rst_instr_cnt", instr_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    nRST = 1'b1;

    foreach (vecs[i]) begin
      chk({vecs[i].name, "_start"}, 32'(state), 32'(FETCH));
      runInstr(vecs[i].ins, vecs[i].z, 0, 1'b0);
      chk({vecs[i].name, "_ir_en"}, 32'(irEnFirst), 1);
      chk({vecs[i].name, "_latency"}, 32'(latency), 32'(vecs[i].lat));
      chk({vecs[i].name, "_regWrite"}, 32'(capRw), 32'(vecs[i].rw));
      chk({vecs[i].name, "_memtoReg"}, 32'(capMtr), 32'(vecs[i].mtr));
      chk({vecs[i].name, "_wdataSrc"}, 32'(capWds), 32'(vecs[i].wds));
      chk({vecs[i].name, "_PCSel"}, 32'(capPcs), 32'(vecs[i].pcs));
      chk({vecs[i].name, "_wsel"}, 32'(capWs), 32'(vecs[i].ws));
      chk({vecs[i].name, "_rsel1"}, 32'(capRs1), 32'(vecs[i].rs1));
      chk({vecs[i].name, "_dREN"}, 32'(rdCycles), vecs[i].rd ? 1 : 0);
      chk({vecs[i].name, "_dWEN"}, 32'(wrCycles), vecs[i].wr ? 1 : 0);
      if (vecs[i].chkSel) begin
        chk({vecs[i].name, "_ALUop"}, 32'(capAop), 32'(vecs[i].aop));
        chk({vecs[i].name, "_aluSrc"}, 32'(capAsrc), 32'(vecs[i].asrc));
      end
      if (vecs[i].chkImm) chk({vecs[i].name, "_imm"}, capImm, vecs[i].imm);
    end

    // ADDU register selects
    instr = 32'h00221821;
    #1 chk("addu_rsel2", 32'(rsel2), 2);
    @(negedge CLK);

    // LW with 3 data waits; stray ihit/dhit outside their states must be ignored
`ifdef MCU_PERF_CNT_EN
    begin
      logic [31:0] stallBefore;
      stallBefore = stall_cnt;
      runInstr(32'h8C220004, 1'b0, 3, 1'b1);
      chk("lw_wait_stall_cnt", stall_cnt - stallBefore, 3);
    end
`else
    runInstr(32'h8C220004, 1'b0, 3, 1'b1);
`endif
    chk("lw_wait_dREN_cycles", 32'(rdCycles), 4);
    chk("lw_wait_latency", 32'(latency), 5);
    chk("lw_wait_total", 32'(totalCycles), 8);
    chk("lw_wait_memtoReg", 32'(capMtr), 1);
    chk("lw_wait_imm", capImm, 32'h4);
    chk("lw_wait_stray_ir_en", 32'(irEnExtra), 0);
    chk("lw_wait_back_fetch", 32'(state), 32'(FETCH));

    // JAL retires exactly one instruction
`ifdef MCU_PERF_CNT_EN
    begin
      logic [31:0] instrBefore;
      instrBefore = instr_cnt;
      runInstr(32'h0C000010, 1'b0, 0, 1'b0);
      chk("jal_instr_cnt", instr_cnt - instrBefore, 1);
    end
`endif

    // Fetch timeout: no ihit -> 4 wait cycles then ERR
    begin
      int fetchCycles;
      fetchCycles = 0;
      instr = 32'h00221821; ihit = 1'b0;
      while (state == FETCH && fetchCycles < 10) begin
        fetchCycles++;
        @(negedge CLK);
      end
      chk("to_fetch_cycles", 32'(fetchCycles), 4);
      chk("to_state", 32'(state), 32'(ERR));
      chk("to_mem_err", 32'(mem_err), 1);
      chk("to_iREN", 32'(iREN), 0);
      ihit = 1'b1; dhit = 1'b1;
      repeat (5) @(negedge CLK);
      #1;
      chk("to_absorbing", 32'(state), 32'(ERR));
      chk("to_requests", {iREN, dREN, dWEN, pc_en}, 0);
      ihit = 1'b0; dhit = 1'b0;
      doReset();
      chk("to_reset_state", {state, mem_err}, {FETCH, 1'b0});
    end

    // Memory timeout on SW with no dhit
    begin
      int memCycles;
      memCycles = 0;
      instr = 32'hAC85FFF8; ihit = 1'b1;
      @(negedge CLK);
      ihit = 1'b0;
      repeat (2) @(negedge CLK);
      while (state == MEM && memCycles < 10) begin
        memCycles++;
        #1 if (memCycles == 1) chk("memto_dWEN", 32'(dWEN), 1);
        @(negedge CLK);
      end
      chk("memto_cycles", 32'(memCycles), 4);
      chk("memto_state", {state, mem_err, dWEN}, {ERR, 1'b1, 1'b0});
      doReset();
    end

    // HALT opcode: absorbing after DECODE
    instr = 32'hFFFFFFFF; ihit = 1'b1;
    @(negedge CLK);
    chk("halt_decode", 32'(state), 32'(DECODE));
    @(negedge CLK);
    chk("halt_state", {state, halt}, {HALT, 1'b1});
    repeat (4) @(negedge CLK);
    #1;
    chk("halt_sticky", {state, halt, iREN, pc_en}, {HALT, 1'b1, 1'b0, 1'b0});
    ihit = 1'b0;
    doReset();
    chk("halt_reset", {state, halt}, {FETCH, 1'b0});

    // Reset while LW waits in MEM
    instr = 32'h8C220004; ihit = 1'b1;
    @(negedge CLK);
    ihit = 1'b0;
    repeat (2) @(negedge CLK);
    #1 chk("rstmem_dREN_before", {state, dREN}, {MEM, 1'b1});
    nRST = 1'b0;
    @(negedge CLK);
    chk("rstmem_after", {state, dREN, iREN}, {FETCH, 1'b0, 1'b1});
    nRST = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, got running, expected finished");
    $fatal(1, "time limit");
  end

endmodule
